// File: rtl/branch_cond_if.sv
// ----------------------------------------------------------------------------
// branch_cond_if
// Bundles the flag inputs, decode-stage branch fields and the registered
// control outputs of the Bicc condition unit. The master side is whatever
// drives decode (datapath or testbench); the slave side is branch_cond_unit.
// ----------------------------------------------------------------------------
interface branch_cond_if;
   // Flags and decode-stage fields presented to the unit
   logic [3:0] flags;          // registered flags: bit3=N, bit2=Z, bit1=V, bit0=C
   logic       step;           // instruction at decode retires this cycle
   logic       br_valid;       // instruction at decode is a Bicc
   logic [3:0] cond;           // Bicc cond field, instr[28:25]
   logic       annul;          // Bicc a bit, instr[29]
   logic [3:0] alu_flags;      // flags being produced by the ALU this cycle
   logic       alu_flags_ld;   // flag register load enable this cycle

   // Registered controls towards fetch/NPC logic
   logic       taken;          // one-cycle pulse: resolved branch is taken
   logic       in_delay_slot;  // instruction now at decode is a delay slot
   logic       annul_slot;     // delay-slot instruction must be squashed
   logic       dcti_err;       // sticky: Bicc seen in a delay slot

   modport master (
      output flags, step, br_valid, cond, annul, alu_flags, alu_flags_ld,
      input  taken, in_delay_slot, annul_slot, dcti_err
   );

   modport slave (
      input  flags, step, br_valid, cond, annul, alu_flags, alu_flags_ld,
      output taken, in_delay_slot, annul_slot, dcti_err
   );
endinterface : branch_cond_if

// File: rtl/branch_cond_unit.sv
// ----------------------------------------------------------------------------
// branch_cond_unit
// Resolves SPARC Bicc conditions against the N Z V C flags and tracks the
// delayed-branch slot (including annulment) for the fetch/NPC control.
//
// Configuration macro:
//   FLAG_BYPASS_EN  - when defined, the ALU flags being loaded this cycle are
//                     forwarded into condition evaluation, so a cc-setting
//                     instruction may be immediately followed by a Bicc.
//                     When undefined, only the flag register is consulted and
//                     alu_flags / alu_flags_ld are ignored.
// ----------------------------------------------------------------------------
module branch_cond_unit (
   input logic          clk,
   input logic          rst_n,
   branch_cond_if.slave bus
);

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,   // no branch pending
      ST_SLOT  = 2'd1,   // delay-slot instruction executes
      ST_ASLOT = 2'd2    // delay-slot instruction is annulled
   } state_e;

   // Bicc cond field encodings that need special handling
   localparam logic [3:0] COND_BA = 4'b1000;

   state_e     state_q;
   logic       taken_q;
   logic       in_delay_slot_q;
   logic       annul_slot_q;
   logic       dcti_err_q;

   logic [3:0] eff_flags;
   logic       cond_true;
   logic       annul_next;

   // Select the flags the condition is evaluated against
`ifdef FLAG_BYPASS_EN
   always_comb begin
      eff_flags = bus.alu_flags_ld ? bus.alu_flags : bus.flags;
   end
`else
   logic unused_bypass;
   assign unused_bypass = ^{bus.alu_flags, bus.alu_flags_ld};

   always_comb begin
      eff_flags = bus.flags;
   end
`endif

   // Decode the Bicc condition: cond[2:0] picks the base test, cond[3] inverts
   always_comb begin
      logic n_f, z_f, v_f, c_f;
      logic base;
      n_f = eff_flags[3];
      z_f = eff_flags[2];
      v_f = eff_flags[1];
      c_f = eff_flags[0];
      // NOTE: every combinational output gets a default before the case so
      // no path leaves it unassigned and no latch is inferred.
      base = 1'b0;
      case (bus.cond[2:0])
         3'b000:  base = 1'b0;               // BN   / BA
         3'b001:  base = z_f;                // BE   / BNE
         3'b010:  base = z_f | (n_f ^ v_f);  // BLE  / BG
         3'b011:  base = n_f ^ v_f;          // BL   / BGE
         3'b100:  base = c_f | z_f;          // BLEU / BGU
         3'b101:  base = c_f;                // BCS  / BCC
         3'b110:  base = n_f;                // BNEG / BPOS
         3'b111:  base = v_f;                // BVS  / BVC
         default: base = 1'b0;
      endcase
      cond_true = base ^ bus.cond[3];
   end

   // The slot is annulled when a=1 and the branch is untaken, or for BA,a
   always_comb begin
      annul_next = bus.annul & (~cond_true | (bus.cond == COND_BA));
   end

   // Slot-tracking FSM with registered control outputs
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q         <= ST_IDLE;
         taken_q         <= 1'b0;
         in_delay_slot_q <= 1'b0;
         annul_slot_q    <= 1'b0;
         dcti_err_q      <= 1'b0;
      end else begin
         // NOTE: state registers use non-blocking assignments so every
         // register samples the pre-edge values regardless of statement order.
         taken_q <= 1'b0;
         case (state_q)
            ST_IDLE: begin
               if (bus.step && bus.br_valid) begin
                  taken_q         <= cond_true;
                  in_delay_slot_q <= 1'b1;
                  annul_slot_q    <= annul_next;
                  state_q         <= annul_next ? ST_ASLOT : ST_SLOT;
               end
            end
            ST_SLOT, ST_ASLOT: begin
               // Stalled slots hold; a retiring slot returns to IDLE and a
               // Bicc sitting in the slot is a DCTI couple, never evaluated.
               if (bus.step) begin
                  state_q         <= ST_IDLE;
                  in_delay_slot_q <= 1'b0;
                  annul_slot_q    <= 1'b0;
                  if (bus.br_valid) begin
                     dcti_err_q <= 1'b1;
                  end
               end
            end
            default: begin
               state_q         <= ST_IDLE;
               in_delay_slot_q <= 1'b0;
               annul_slot_q    <= 1'b0;
            end
         endcase
      end
   end

   assign bus.taken         = taken_q;
   assign bus.in_delay_slot = in_delay_slot_q;
   assign bus.annul_slot    = annul_slot_q;
   assign bus.dcti_err      = dcti_err_q;

endmodule : branch_cond_unit

// File: tb/tb_branch_cond_unit.sv
// ----------------------------------------------------------------------------
// tb_branch_cond_unit
// Self-checking bench for branch_cond_unit: directed vector table, full
// condition/flag sweep, hand-written stall / DCTI / reset sequences and a
// randomized run against a behavioural model of the Bicc rules.
// ----------------------------------------------------------------------------
module tb_branch_cond_unit;

   logic clk;
   logic rst_n;

   branch_cond_if bus ();

   branch_cond_unit dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;

   // Behavioural model state: what the unit should currently be showing
   logic m_taken, m_slot, m_annul, m_err;

   typedef struct {
      string      name;
      logic [3:0] cond;
      logic       annul;
      logic [3:0] flags;
      logic       exp_taken;
      logic       exp_annul;
   } vec_t;

   vec_t vecs [12];

   // Bicc condition straight from the mnemonic table
   function automatic logic ref_cond(input logic [3:0] c, input logic [3:0] f);
      logic n, z, v, cy;
      n = f[3]; z = f[2]; v = f[1]; cy = f[0];
      case (c)
         4'b1000: return 1'b1;             // BA
         4'b0000: return 1'b0;             // BN
         4'b1001: return !z;               // BNE
         4'b0001: return z;                // BE
         4'b1010: return !(z || (n != v)); // BG
         4'b0010: return z || (n != v);    // BLE
         4'b1011: return n == v;           // BGE
         4'b0011: return n != v;           // BL
         4'b1100: return !(cy || z);       // BGU
         4'b0100: return cy || z;          // BLEU
         4'b1101: return !cy;              // BCC
         4'b0101: return cy;               // BCS
         4'b1110: return !n;               // BPOS
         4'b0110: return n;                // BNEG
         4'b1111: return !v;               // BVC
         default: return v;                // BVS
      endcase
   endfunction

   function automatic logic [3:0] model_flags();
`ifdef FLAG_BYPASS_EN
      return bus.alu_flags_ld ? bus.alu_flags : bus.flags;
`else
      return bus.flags;
`endif
   endfunction

   // Advance the model by one clock edge using the inputs now applied
   task automatic model_edge();
      logic c;
      if (!m_slot) begin
         if (bus.step && bus.br_valid) begin
            c       = ref_cond(bus.cond, model_flags());
            m_taken = c;
            m_slot  = 1'b1;
            m_annul = bus.annul && (!c || bus.cond == 4'b1000);
         end else begin
            m_taken = 1'b0;
         end
      end else begin
         m_taken = 1'b0;
         if (bus.step) begin
            m_slot  = 1'b0;
            m_annul = 1'b0;
            if (bus.br_valid) m_err = 1'b1;
         end
      end
   endtask

   task automatic check(input string name, input logic [3:0] act, input logic [3:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got {taken,slot,annul,err}=%b expected %b", name, act, exp);
      end
   endtask

   function automatic logic [3:0] dut_out();
      return {bus.taken, bus.in_delay_slot, bus.annul_slot, bus.dcti_err};
   endfunction

   function automatic logic [3:0] model_out();
      return {m_taken, m_slot, m_annul, m_err};
   endfunction

   // One clock edge, then compare against the model
   task automatic tick(input string name);
      @(posedge clk);
      model_edge();
      #1;
      check(name, dut_out(), model_out());
   endtask

   task automatic set_in(input logic step, input logic bv, input logic [3:0] c,
                         input logic a, input logic [3:0] f);
      bus.step     = step;
      bus.br_valid = bv;
      bus.cond     = c;
      bus.annul    = a;
      bus.flags    = f;
   endtask

   task automatic apply_reset();
      rst_n   = 1'b0;
      m_taken = 1'b0; m_slot = 1'b0; m_annul = 1'b0; m_err = 1'b0;
      #1;
      check("reset", dut_out(), 4'b0000);
      @(posedge clk); #1;
      rst_n = 1'b1;
   endtask

   initial begin
      vecs[0]  = '{"BE_Z",      4'b0001, 1'b0, 4'b0100, 1'b1, 1'b0};
      vecs[1]  = '{"BNE_a_Z",   4'b1001, 1'b1, 4'b0100, 1'b0, 1'b1};
      vecs[2]  = '{"BNE_Z",     4'b1001, 1'b0, 4'b0100, 1'b0, 1'b0};
      vecs[3]  = '{"BA_a",      4'b1000, 1'b1, 4'b0000, 1'b1, 1'b1};
      vecs[4]  = '{"BN_a",      4'b0000, 1'b1, 4'b0000, 1'b0, 1'b1};
      vecs[5]  = '{"BL_N",      4'b0011, 1'b0, 4'b1000, 1'b1, 1'b0};
      vecs[6]  = '{"BL_NV",     4'b0011, 1'b0, 4'b1010, 1'b0, 1'b0};
      vecs[7]  = '{"BGU_C",     4'b1100, 1'b0, 4'b0001, 1'b0, 1'b0};
      vecs[8]  = '{"BGE_NV",    4'b1011, 1'b0, 4'b1010, 1'b1, 1'b0};
      vecs[9]  = '{"BLEU_a_C",  4'b0100, 1'b1, 4'b0001, 1'b1, 1'b0};
      vecs[10] = '{"BG_a_0",    4'b1010, 1'b1, 4'b0000, 1'b1, 1'b0};
      vecs[11] = '{"BCS_a_0",   4'b0101, 1'b1, 4'b0000, 1'b0, 1'b1};

      bus.alu_flags    = 4'b0000;
      bus.alu_flags_ld = 1'b0;
      set_in(1'b0, 1'b0, 4'b0000, 1'b0, 4'b0000);
      apply_reset();

      // Directed table: branch from IDLE, then retire the slot
      foreach (vecs[i]) begin
         set_in(1'b1, 1'b1, vecs[i].cond, vecs[i].annul, vecs[i].flags);
         @(posedge clk); model_edge(); #1;
         check({vecs[i].name, "_br"}, dut_out(),
               {vecs[i].exp_taken, 1'b1, vecs[i].exp_annul, 1'b0});
         set_in(1'b1, 1'b0, 4'b0000, 1'b0, 4'b0000);
         @(posedge clk); model_edge(); #1;
         check({vecs[i].name, "_ret"}, dut_out(), 4'b0000);
         set_in(1'b0, 1'b0, 4'b0000, 1'b0, 4'b0000);
      end

      // All conditions against the signed/unsigned flag patterns
      begin
         logic [3:0] fl [6];
         fl = '{4'b0000, 4'b1000, 4'b0010, 4'b1010, 4'b0001, 4'b0101};
         for (int c = 0; c < 16; c++) begin
            for (int k = 0; k < 6; k++) begin
               set_in(1'b1, 1'b1, 4'(c), 1'($urandom_range(0, 1)), fl[k]);
               tick($sformatf("sweep_c%0d_f%b", c, fl[k]));
               set_in(1'b1, 1'b0, 4'b0000, 1'b0, 4'b0000);
               tick($sformatf("sweep_ret_c%0d_f%b", c, fl[k]));
            end
         end
      end

      // Stall in SLOT for three cycles: state held, taken a single pulse
      set_in(1'b1, 1'b1, 4'b0001, 1'b0, 4'b0100);
      @(posedge clk); model_edge(); #1;
      check("stall_br", dut_out(), 4'b1100);
      set_in(1'b0, 1'b1, 4'b1000, 1'b1, 4'b1111);
      for (int s = 0; s < 3; s++) begin
         @(posedge clk); model_edge(); #1;
         check($sformatf("stall_hold%0d", s), dut_out(), 4'b0100);
      end

      // DCTI couple: Bicc retiring in the slot sets the sticky error
      set_in(1'b1, 1'b1, 4'b1000, 1'b0, 4'b0000);
      @(posedge clk); model_edge(); #1;
      check("dcti_set", dut_out(), 4'b0001);
      set_in(1'b1, 1'b0, 4'b0000, 1'b0, 4'b0000);
      for (int s = 0; s < 2; s++) begin
         @(posedge clk); model_edge(); #1;
         check($sformatf("dcti_sticky%0d", s), dut_out(), 4'b0001);
      end
      apply_reset();

      // Asynchronous reset in the middle of an annulled slot
      set_in(1'b1, 1'b1, 4'b0000, 1'b1, 4'b0000);
      @(posedge clk); model_edge(); #1;
      check("aslot_enter", dut_out(), 4'b0110);
      set_in(1'b0, 1'b0, 4'b0000, 1'b0, 4'b0000);
      #2;
      apply_reset();
      set_in(1'b1, 1'b0, 4'b0000, 1'b0, 4'b0000);
      tick("after_reset_idle");

      // Flag bypass: ALU flags loading this cycle vs stale flag register
      bus.alu_flags    = 4'b0100;
      bus.alu_flags_ld = 1'b1;
      set_in(1'b1, 1'b1, 4'b0001, 1'b0, 4'b0000);
      @(posedge clk); model_edge(); #1;
`ifdef FLAG_BYPASS_EN
      check("bypass_BE", dut_out(), 4'b1100);
`else
      check("bypass_BE", dut_out(), 4'b0100);
`endif
      bus.alu_flags_ld = 1'b0;
      set_in(1'b1, 1'b0, 4'b0000, 1'b0, 4'b0000);
      tick("bypass_ret");

      // Randomized run against the model
      apply_reset();
      for (int n = 0; n < 400; n++) begin
         bus.alu_flags    = 4'($urandom);
         bus.alu_flags_ld = 1'($urandom);
         set_in(1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 2) == 0),
                4'($urandom), 1'($urandom), 4'($urandom));
         tick($sformatf("rand%0d", n));
         if (n == 200) apply_reset();
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule : tb_branch_cond_unit

// File: doc/branch_cond_unit.md
Name: branch_cond_unit

Overview:
- Consumer side of the flag register: reads the registered N Z V C flags and resolves SPARC Bicc conditions.
- Tracks the delayed-branch slot, including the annul semantics, and produces registered control signals to the fetch/NPC logic.
- Sits between the flag register output and the PC/NPC load control in the Phase 4 datapath.

Parameters:
- none

Ports:
- clk  input  1  system clock, rising edge
- rst_n  input  1  asynchronous active-low reset
- flags  input  4  registered flags from the flag register; bit3=N, bit2=Z, bit1=V, bit0=C
- step  input  1  pipeline advance strobe; the instruction at decode retires this cycle
- br_valid  input  1  instruction at decode is a Bicc
- cond  input  4  Bicc cond field, instr[28:25]
- annul  input  1  Bicc a bit, instr[29]
- alu_flags  input  4  flags being produced by the ALU this cycle (used only with the optional feature)
- alu_flags_ld  input  1  flag register load enable this cycle (used only with the optional feature)
- taken  output  1  one-cycle pulse: the resolved branch is taken
- in_delay_slot  output  1  instruction now at decode is a delay-slot instruction
- annul_slot  output  1  the delay-slot instruction must be squashed (no register or flag writeback)
- dcti_err  output  1  sticky: a Bicc was presented in a delay slot

Behaviour:
- Reset (rst_n low, asynchronous): state=IDLE; taken=0, in_delay_slot=0, annul_slot=0, dcti_err=0.
- Condition decode is combinational on the effective flags (f):
  - 1000 BA=1; 0000 BN=0
  - 1001 BNE=~Z; 0001 BE=Z
  - 1010 BG=~(Z|(N^V)); 0010 BLE=Z|(N^V)
  - 1011 BGE=~(N^V); 0011 BL=N^V
  - 1100 BGU=~(C|Z); 0100 BLEU=C|Z
  - 1101 BCC=~C; 0101 BCS=C
  - 1110 BPOS=~N; 0110 BNEG=N
  - 1111 BVC=~V; 0111 BVS=V
- States: IDLE, SLOT (execute delay slot), ASLOT (annul delay slot). All outputs are registered.
- IDLE with step & br_valid: evaluate c=cond_true.
  - Next cycle: taken=c.
  - Next state is ASLOT if annul=1 and (c=0 or cond=1000); otherwise SLOT.
  - BA with a=1 annuls its slot even though taken. BN with a=1 annuls its slot.
- IDLE with step & ~br_valid: stay IDLE; taken=0.
- SLOT/ASLOT: in_delay_slot=1; annul_slot=1 only in ASLOT. taken drops to 0 after one cycle regardless of step.
- SLOT/ASLOT with step: return to IDLE.
  - If br_valid=1 in the same cycle (DCTI couple): no evaluation, taken stays 0, dcti_err sets and holds until reset.
- SLOT/ASLOT with ~step: hold state and outputs (stall); taken still drops after its single cycle.
- ~step in any state: no evaluation; cond, annul and flags are ignored.
- Latency: decode-to-taken is 1 cycle. Slot indication is asserted from the cycle after branch retirement until the slot retires.
- Reset mid-slot: immediate return to IDLE; the slot is not annulled.

Optional Feature:
- Macro: FLAG_BYPASS_EN
- Defined: f = alu_flags_ld ? alu_flags : flags. This covers a cc-setting instruction immediately followed by a Bicc, where the flag register has not yet updated.
- Undefined: f = flags. alu_flags and alu_flags_ld are ignored, and the instruction scheduler guarantees one cycle between a cc write and a Bicc.

Test Plan:
- Reset/basic: rst_n low, flags=0000 → all outputs 0. Release, step=1, br_valid=1, cond=0001 (BE), flags=0100 → next cycle taken=1, in_delay_slot=1, annul_slot=0. Next step → IDLE, all 0.
- Annul not-taken: cond=1001 (BNE), annul=1, flags=0100 → taken=0, in_delay_slot=1, annul_slot=1. BNE with a=0 under the same flags → annul_slot=0.
- BA,a / BN,a: cond=1000, annul=1 → taken=1, annul_slot=1. cond=0000, annul=1 → taken=0, annul_slot=1.
- Signed/unsigned sweep: all 16 conds against flags 0000, 1000, 0010, 1010, 0001, 0101 → taken matches the decode table (e.g. BL with 1000 → 1; BL with 1010 → 0; BGU with 0001 → 0).
- Stall/DCTI: hold step=0 for 3 cycles in SLOT → state held, taken a single-cycle pulse. Then step=1 with br_valid=1 → IDLE, taken=0, dcti_err=1 until rst_n low. Assert rst_n low mid-ASLOT → IDLE immediately.
- Bypass (FLAG_BYPASS_EN): flags=0000, alu_flags=0100, alu_flags_ld=1, BE → taken=1. Without the macro → taken=0.
